// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters. Grants are
// round-robin and one operation is in flight at a time. The granted operands
// are registered and drive the ALU. The ALU outputs are captured into a
// response register, which is held until the consumer takes it.
//
// Optional feature (macro ALU_ARB_FUNCT_CHECK_EN):
//   When defined, a funct outside 27..32 still completes. Its response is
//   forced to result=0, zero=1, carry=0, err=1, and the ALU outputs are
//   ignored. When undefined, rsp_err is tied low and every funct goes to the
//   ALU unchanged.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   reqN_valid / reqN_ready  request handshake, N = 0,1
//   reqN_src1/src2/funct/shamt  request operands
//   alu_src1/src2/funct/shamt   registered operands to the ALU
//   alu_result/zero/carry       combinational ALU outputs
//   rsp_valid / rsp_ready    response handshake
//   rsp_id                   index of the requester that owns the response
//   rsp_result/zero/carry    captured ALU outputs
//   rsp_err                  illegal-funct flag (optional feature only)
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int DATA_W  = 32,
    parameter int FUNCT_W = 6,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [DATA_W-1:0]  req0_src1,
    input  logic [DATA_W-1:0]  req0_src2,
    input  logic [FUNCT_W-1:0] req0_funct,
    input  logic [SHAMT_W-1:0] req0_shamt,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [DATA_W-1:0]  req1_src1,
    input  logic [DATA_W-1:0]  req1_src2,
    input  logic [FUNCT_W-1:0] req1_funct,
    input  logic [SHAMT_W-1:0] req1_shamt,

    output logic [DATA_W-1:0]  alu_src1,
    output logic [DATA_W-1:0]  alu_src2,
    output logic [FUNCT_W-1:0] alu_funct,
    output logic [SHAMT_W-1:0] alu_shamt,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_zero,
    input  logic               alu_carry,

    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [DATA_W-1:0]  rsp_result,
    output logic               rsp_zero,
    output logic               rsp_carry,
    output logic               rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic               gnt_id_q, gnt_id_d;
    logic [DATA_W-1:0]  src1_q, src1_d;
    logic [DATA_W-1:0]  src2_q, src2_d;
    logic [FUNCT_W-1:0] funct_q, funct_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]  rsp_result_q, rsp_result_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_carry_q, rsp_carry_d;

    logic               idle;
    logic               any_valid;
    logic               grant1;

`ifdef ALU_ARB_FUNCT_CHECK_EN
    logic               rsp_err_q, rsp_err_d;
    logic               funct_illegal;

    // Legal ALU codes are the contiguous range 27..32.
    assign funct_illegal = (funct_q < FUNCT_W'(27)) || (funct_q > FUNCT_W'(32));
`endif

    // Requester 1 wins when it is the only one asking or when it is the
    // preferred requester. Otherwise requester 0 wins whenever it is valid.
    assign idle       = (state_q == IDLE);
    assign any_valid  = req0_valid | req1_valid;
    assign grant1     = req1_valid & (~req0_valid | rr_ptr_q);
    assign req0_ready = idle & req0_valid & ~grant1;
    assign req1_ready = idle & grant1;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_id_d     = gnt_id_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        funct_d      = funct_q;
        shamt_d      = shamt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_carry_d  = rsp_carry_q;
`ifdef ALU_ARB_FUNCT_CHECK_EN
        rsp_err_d    = rsp_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    src1_d   = grant1 ? req1_src1  : req0_src1;
                    src2_d   = grant1 ? req1_src2  : req0_src2;
                    funct_d  = grant1 ? req1_funct : req0_funct;
                    shamt_d  = grant1 ? req1_shamt : req0_shamt;
                    gnt_id_d = grant1;
                    // The requester that just lost (or did not ask) gets
                    // priority next time.
                    rr_ptr_d = ~grant1;
                    state_d  = EXEC;
                end
            end

            EXEC: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_carry_d  = alu_carry;
`ifdef ALU_ARB_FUNCT_CHECK_EN
                rsp_err_d    = 1'b0;
                if (funct_illegal) begin
                    rsp_result_d = '0;
                    rsp_zero_d   = 1'b1;
                    rsp_carry_d  = 1'b0;
                    rsp_err_d    = 1'b1;
                end
`endif
                rsp_id_d    = gnt_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end

            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // An asynchronous reset throws away any operation in flight. The operand
    // registers are also cleared, so the ALU inputs read zero right away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 1'b0;
            gnt_id_q     <= 1'b0;
            src1_q       <= '0;
            src2_q       <= '0;
            funct_q      <= '0;
            shamt_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_carry_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_id_q     <= gnt_id_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            funct_q      <= funct_d;
            shamt_q      <= shamt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_carry_q  <= rsp_carry_d;
        end
    end

`ifdef ALU_ARB_FUNCT_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign alu_src1   = src1_q;
    assign alu_src2   = src2_q;
    assign alu_funct  = funct_q;
    assign alu_shamt  = shamt_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_carry  = rsp_carry_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed testbench for alu_arbiter. A small behavioural ALU closes the
// loop on the alu_* ports. Expected values are worked out by hand for each
// step. Define ALU_ARB_FUNCT_CHECK_EN to exercise the illegal-funct variant.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
    logic [5:0]  req0_funct, req1_funct;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic [5:0]  alu_funct;
    logic [4:0]  alu_shamt;
    logic        alu_zero, alu_carry;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_carry, rsp_err;
    logic [31:0] rsp_result;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.DATA_W(32), .FUNCT_W(6), .SHAMT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_src1  (req0_src1),
        .req0_src2  (req0_src2),
        .req0_funct (req0_funct),
        .req0_shamt (req0_shamt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_src1  (req1_src1),
        .req1_src2  (req1_src2),
        .req1_funct (req1_funct),
        .req1_shamt (req1_shamt),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_funct  (alu_funct),
        .alu_shamt  (alu_shamt),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_carry  (rsp_carry),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU. The sub carry is the 33-bit borrow. The srl carry is
    // the last bit shifted out, Src1[shamt-1] with the index wrapping mod 32.
    // The sll carry is the last bit shifted out at the top.
    always_comb begin
        logic [32:0] wide;
        logic [4:0]  idx;
        wide       = 33'd0;
        idx        = alu_shamt - 5'd1;
        alu_result = alu_src2;
        alu_carry  = 1'b0;
        case (alu_funct)
            6'd27: begin
                wide       = {1'b0, alu_src1} + {1'b0, alu_src2};
                alu_result = wide[31:0];
                alu_carry  = wide[32];
            end
            6'd28: begin
                wide       = {1'b0, alu_src1} - {1'b0, alu_src2};
                alu_result = wide[31:0];
                alu_carry  = wide[32];
            end
            6'd29: alu_result = alu_src1 & alu_src2;
            6'd30: alu_result = alu_src1 | alu_src2;
            6'd31: begin
                alu_result = alu_src1 >> alu_shamt;
                alu_carry  = alu_src1[idx];
            end
            6'd32: begin
                alu_result = alu_src1 << alu_shamt;
                alu_carry  = (alu_shamt == 5'd0) ? 1'b0 : alu_src1[6'd32 - {1'b0, alu_shamt}];
            end
            default: alu_result = alu_src2;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    // Drive one requester's inputs.
    task automatic applyStimulus(input int idx, input logic valid,
                                 input logic [31:0] src1, input logic [31:0] src2,
                                 input logic [5:0] funct, input logic [4:0] shamt);
        if (idx == 0) begin
            req0_valid = valid;
            req0_src1  = src1;
            req0_src2  = src2;
            req0_funct = funct;
            req0_shamt = shamt;
        end else begin
            req1_valid = valid;
            req1_src1  = src1;
            req1_src2  = src2;
            req1_funct = funct;
            req1_shamt = shamt;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one clock, then settle 1 time unit past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRsp(input string tag, input logic id, input logic [31:0] result,
                            input logic zero, input logic carry);
        checkOutput({tag, "_valid"},  32'(rsp_valid), 32'd1);
        checkOutput({tag, "_id"},     32'(rsp_id),    32'(id));
        checkOutput({tag, "_result"}, rsp_result,     result);
        checkOutput({tag, "_zero"},   32'(rsp_zero),  32'(zero));
        checkOutput({tag, "_carry"},  32'(rsp_carry), 32'(carry));
    endtask

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b1;
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 6'd0, 5'd0);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 6'd0, 5'd0);
        step();
        step();

        // Reset values.
        checkOutput("rst_req0_ready", 32'(req0_ready), 32'd0);
        checkOutput("rst_req1_ready", 32'(req1_ready), 32'd0);
        checkOutput("rst_alu_src1",   alu_src1,        32'd0);
        checkOutput("rst_alu_src2",   alu_src2,        32'd0);
        checkOutput("rst_alu_funct",  32'(alu_funct),  32'd0);
        checkOutput("rst_alu_shamt",  32'(alu_shamt),  32'd0);
        checkOutput("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        checkOutput("rst_rsp_id",     32'(rsp_id),     32'd0);
        checkOutput("rst_rsp_result", rsp_result,      32'd0);
        checkOutput("rst_rsp_zero",   32'(rsp_zero),   32'd0);
        checkOutput("rst_rsp_carry",  32'(rsp_carry),  32'd0);
        checkOutput("rst_rsp_err",    32'(rsp_err),    32'd0);
        rst = 1'b0;
        step();

        // Add 0xFFFFFFFF + 1: result 0, zero=1, carry=1.
        // Operands change after the accepting edge and must be ignored.
        applyStimulus(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 6'd27, 5'd0);
        #1;
        checkOutput("add_req0_ready", 32'(req0_ready), 32'd1);
        checkOutput("add_req1_ready", 32'(req1_ready), 32'd0);
        step();
        applyStimulus(0, 1'b0, 32'h1234_5678, 32'h9, 6'd29, 5'd3);
        checkOutput("add_exec_alu_src1", alu_src1, 32'hFFFF_FFFF);
        checkOutput("add_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("add_exec_req0_ready", 32'(req0_ready), 32'd0);
        step();
        checkRsp("add", 1'b0, 32'd0, 1'b1, 1'b1);
        checkOutput("add_err", 32'(rsp_err), 32'd0);
        step();
        checkOutput("add_done_rsp_valid", 32'(rsp_valid), 32'd0);

        // Start the round-robin from a known pointer of 0.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        step();

        // Both valid: req0 subtracts 5-7 first, then req1 ORs 0xF0|0x0F.
        applyStimulus(0, 1'b1, 32'd5, 32'd7, 6'd28, 5'd0);
        applyStimulus(1, 1'b1, 32'hF0, 32'h0F, 6'd30, 5'd0);
        #1;
        checkOutput("both_req0_ready", 32'(req0_ready), 32'd1);
        checkOutput("both_req1_ready", 32'(req1_ready), 32'd0);
        step();
        checkOutput("both_exec_req0_ready", 32'(req0_ready), 32'd0);
        checkOutput("both_exec_req1_ready", 32'(req1_ready), 32'd0);
        step();
        checkRsp("sub", 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1);
        checkOutput("sub_resp_req1_ready", 32'(req1_ready), 32'd0);
        step();
        checkOutput("or_idle_req1_ready", 32'(req1_ready), 32'd1);
        checkOutput("or_idle_req0_ready", 32'(req0_ready), 32'd0);
        step();
        step();
        checkRsp("or", 1'b1, 32'h0000_00FF, 1'b0, 1'b0);
        step();
        checkOutput("alt_req0_ready", 32'(req0_ready), 32'd1);
        checkOutput("alt_req1_ready", 32'(req1_ready), 32'd0);

        // req0 drops out, so req1 is granted even though req0 is preferred.
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 6'd0, 5'd0);
        applyStimulus(1, 1'b1, 32'h8000_0001, 32'd0, 6'd31, 5'd1);
        #1;
        checkOutput("srl_req1_ready", 32'(req1_ready), 32'd1);
        step();
        step();
        checkRsp("srl", 1'b1, 32'h4000_0000, 1'b0, 1'b1);
        step();

        applyStimulus(1, 1'b1, 32'h8000_0000, 32'd0, 6'd32, 5'd1);
        #1;
        checkOutput("sll_req1_ready", 32'(req1_ready), 32'd1);
        step();
        step();
        checkRsp("sll", 1'b1, 32'd0, 1'b1, 1'b1);
        step();

        // Backpressure. The pointer now prefers req0, so req0 goes first
        // (1 + 2), and the response must hold for 5 stalled cycles.
        rsp_ready = 1'b0;
        applyStimulus(0, 1'b1, 32'd1, 32'd2, 6'd27, 5'd0);
        applyStimulus(1, 1'b1, 32'hFF00_FF00, 32'h0FF0_0FF0, 6'd29, 5'd0);
        #1;
        checkOutput("bp_req0_ready", 32'(req0_ready), 32'd1);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            checkRsp("bp_hold", 1'b0, 32'd3, 1'b0, 1'b0);
            checkOutput("bp_hold_req0_ready", 32'(req0_ready), 32'd0);
            checkOutput("bp_hold_req1_ready", 32'(req1_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        checkOutput("bp_done_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("bp_next_req1_ready", 32'(req1_ready), 32'd1);
        checkOutput("bp_next_req0_ready", 32'(req0_ready), 32'd0);

        // Reset in EXEC: req1 AND is accepted, then reset hits. Valids drop
        // at the same moment, so the readies can be checked too.
        step();
        checkOutput("rx_exec_alu_funct", 32'(alu_funct), 32'd29);
        rst = 1'b1;
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 6'd0, 5'd0);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 6'd0, 5'd0);
        #1;
        checkOutput("rx_alu_src1",   alu_src1,        32'd0);
        checkOutput("rx_alu_funct",  32'(alu_funct),  32'd0);
        checkOutput("rx_rsp_valid",  32'(rsp_valid),  32'd0);
        checkOutput("rx_req0_ready", 32'(req0_ready), 32'd0);
        checkOutput("rx_req1_ready", 32'(req1_ready), 32'd0);
        step();
        rst = 1'b0;
        step();
        checkOutput("rx_no_rsp", 32'(rsp_valid), 32'd0);
        applyStimulus(0, 1'b1, 32'd0, 32'h1234, 6'd40, 5'd0);
        applyStimulus(1, 1'b1, 32'd0, 32'h5555, 6'd27, 5'd0);
        #1;
        checkOutput("rx_next_req0_ready", 32'(req0_ready), 32'd1);
        checkOutput("rx_next_req1_ready", 32'(req1_ready), 32'd0);

        // Illegal funct 40 with src2 = 0x1234, granted to req0.
        step();
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 6'd0, 5'd0);
        step();
`ifdef ALU_ARB_FUNCT_CHECK_EN
        checkRsp("ill", 1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("ill_err", 32'(rsp_err), 32'd1);
`else
        checkRsp("ill", 1'b0, 32'h1234, 1'b0, 1'b0);
        checkOutput("ill_err", 32'(rsp_err), 32'd0);
`endif
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 6'd0, 5'd0);
        step();
        checkOutput("ill_done_rsp_valid", 32'(rsp_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
